// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : Byte-oriented SPI target (SCLK idle low, sample on rise, shift on
//            fall, MSB first, CS active low). SCLK, CS and MOSI are
//            oversampled on clk. Received bytes appear on rx_data with a
//            one-cycle rx_valid strobe. A locally loaded byte is shifted out
//            on MISO. Supports single-byte frames and continuous multi-byte
//            transfers under one CS assertion.
// Ports    : clk         - system clock, rising edge
//            rst         - synchronous reset, active low
//            SCLK/CS/MOSI- asynchronous SPI pins from the master
//            MISO        - serial data out, high impedance outside SHIFT
//            tx_data     - byte to transmit, written by the tx_load strobe
//            tx_load     - one-cycle write strobe for tx_buf
//            tx_ready    - tx_buf holds no unconsumed byte
//            tx_underrun - one-cycle pulse: a byte started from a stale tx_buf
//            rx_data     - last complete received byte
//            rx_valid    - one-cycle pulse when rx_data updates
//            busy        - frame in progress (SHIFT state)
// Params   : SYNC_STAGES - synchroniser depth, 2..3
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers. MOSI uses the same depth as SCLK so that the data bit seen
  // together with a detected SCLK rise is the one the master presented.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   cs_dly_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s &  sclk_dly_q;
  assign cs_rise   =  cs_s   & ~cs_dly_q;
  assign cs_fall   = ~cs_s   &  cs_dly_q;

  // --------------------------------------------------------------------------
  // Frame state and datapath registers
  // --------------------------------------------------------------------------
  state_t     state_q,     state_d;
  logic [7:0] tx_buf_q,    tx_buf_d;
  logic       pending_q,   pending_d;
  logic [7:0] tx_shift_q,  tx_shift_d;
  logic [7:0] rx_shift_q,  rx_shift_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic       rise_seen_q, rise_seen_d;
  logic       byte_end_q,  byte_end_d;
  logic [7:0] rx_data_q,   rx_data_d;
  logic       rx_valid_q,  rx_valid_d;
  logic       underrun_q,  underrun_d;
  logic       copy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tx_buf_q    <= 8'h00;
      pending_q   <= 1'b0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      bit_cnt_q   <= 3'd0;
      rise_seen_q <= 1'b0;
      byte_end_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_buf_q    <= tx_buf_d;
      pending_q   <= pending_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rise_seen_q <= rise_seen_d;
      byte_end_q  <= byte_end_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_buf_d    = tx_buf_q;
    pending_d   = pending_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    rise_seen_d = rise_seen_q;
    byte_end_d  = byte_end_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    copy        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_SHIFT;
          copy        = 1'b1;
          bit_cnt_d   = 3'd0;
          rise_seen_d = 1'b0;
          byte_end_d  = 1'b0;
        end
      end

      ST_SHIFT: begin
        // CS release wins over any SCLK edge in the same cycle and throws
        // away a partially received byte.
        if (cs_rise) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = 3'd0;
          rise_seen_d = 1'b0;
          byte_end_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d  = {rx_shift_q[6:0], mosi_s};
          rise_seen_d = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q[6:0], mosi_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = 3'd0;
            byte_end_d = 1'b1;
          end else begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end
        end else if (sclk_fall && rise_seen_q) begin
          // A fall before any rise is the master parking SCLK low after a
          // frame that ended with SCLK high; shifting there would lose bit 7.
          if (byte_end_q) begin
            copy       = 1'b1;
            byte_end_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A copy always takes the current tx_buf; a same-cycle tx_load lands in
    // tx_buf afterwards and leaves the new byte pending.
    if (copy) begin
      tx_shift_d = tx_buf_q;
      pending_d  = 1'b0;
      underrun_d = ~pending_q;
    end
    if (tx_load) begin
      tx_buf_d  = tx_data;
      pending_d = 1'b1;
    end
  end

  assign MISO        = (state_q == ST_SHIFT) ? tx_shift_q[7] : 1'bz;
  assign busy        = (state_q == ST_SHIFT);
  assign tx_ready    = ~pending_q;
  assign tx_underrun = underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Directed self-checking bench for spi_slave. A behavioural SPI
//            master drives 50-cycle SCLK half-periods; a monitor records
//            rx_valid bytes and tx_underrun pulses. MISO carries a pull-up so
//            an undriven (high impedance) MISO reads as 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       SCLK;
  logic       CS;
  logic       MOSI;
  wire        MISO;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  pullup (MISO);

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .SCLK       (SCLK),
    .CS         (CS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         cyc_cnt = 0;
  int         rxv_cnt = 0;
  int         und_cnt = 0;
  int         rxv_cyc = 0;
  int         last_rise = 0;
  logic [7:0] rx_log [0:63];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Every cycle rx_valid is high logs one byte, so a stretched strobe shows
  // up as an extra entry.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_log[rxv_cnt[5:0]] = rx_data;
      rxv_cnt = rxv_cnt + 1;
      rxv_cyc = cyc_cnt;
    end
    if (tx_underrun === 1'b1) und_cnt = und_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
  endtask

  // One CS-low frame of nbits bits, MSB-aligned in mosi. MISO is sampled at
  // the end of each SCLK-low phase. final_fall=0 leaves SCLK high at the end.
  // load_bit >= 0 pulses tx_load with load_val during that bit's high phase.
  task automatic frame(input int nbits, input logic [15:0] mosi,
                       input bit final_fall, input int load_bit,
                       input logic [7:0] load_val, input int gap,
                       output logic [15:0] miso_bits);
    miso_bits = '0;
    CS = 1'b0;
    if (SCLK) begin
      cyc(HALF);
      SCLK = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi[15-i];
      cyc(HALF);
      miso_bits[15-i] = MISO;
      SCLK = 1'b1;
      last_rise = cyc_cnt;
      if (i == load_bit) begin
        load(load_val);
        cyc(HALF - 1);
      end else begin
        cyc(HALF);
      end
      if (i < nbits - 1 || final_fall) SCLK = 1'b0;
    end
    cyc(HALF);
    CS   = 1'b1;
    MOSI = 1'b0;
    cyc(gap);
  endtask

  task automatic test_reset();
    rst = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      SCLK = ~SCLK;
      cyc(1);
    end
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL reset_miso: got %b want z(pulled 1)", MISO); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (tx_underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", tx_underrun); end
    rst = 1'b1; SCLK = 1'b0;
    cyc(10);
    total++; if (rxv_cnt !== 0) begin bad++; $display("FAIL reset_rx_valid: got %0d pulses want 0", rxv_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [15:0] mb;
    int r0;
    load(8'h3C);
    cyc(1);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL single_tx_ready_loaded: got %b want 0", tx_ready); end
    r0 = rxv_cnt;
    frame(8, 16'hA500, 1'b1, -1, 8'h00, 20, mb);
    total++; if (mb[15:8] !== 8'h3C) begin bad++; $display("FAIL single_miso: got %h want 3c", mb[15:8]); end
    total++; if (rxv_cnt - r0 !== 1) begin bad++; $display("FAIL single_rx_count: got %0d want 1", rxv_cnt - r0); end
    total++; if (rx_log[r0[5:0]] !== 8'hA5) begin bad++; $display("FAIL single_rx_byte: got %h want a5", rx_log[r0[5:0]]); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_rx_hold: got %h want a5", rx_data); end
    total++; if (rxv_cyc - last_rise !== 3) begin bad++; $display("FAIL single_rx_latency: got %0d want 3", rxv_cyc - last_rise); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL single_tx_ready_after: got %b want 1", tx_ready); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] mb1, mb2;
    int r0;
    load(8'h81);
    r0 = rxv_cnt;
    frame(8, 16'h1200, 1'b0, 2, 8'hC3, 4, mb1);
    frame(8, 16'h7F00, 1'b0, -1, 8'h00, 20, mb2);
    total++; if (rxv_cnt - r0 !== 2) begin bad++; $display("FAIL b2b_rx_count: got %0d want 2", rxv_cnt - r0); end
    total++; if (rx_log[r0[5:0]] !== 8'h12) begin bad++; $display("FAIL b2b_rx0: got %h want 12", rx_log[r0[5:0]]); end
    total++; if (rx_log[(r0 + 1) % 64] !== 8'h7F) begin bad++; $display("FAIL b2b_rx1: got %h want 7f", rx_log[(r0 + 1) % 64]); end
    total++; if (mb1[15:8] !== 8'h81) begin bad++; $display("FAIL b2b_miso0: got %h want 81", mb1[15:8]); end
    total++; if (mb2[15:8] !== 8'hC3) begin bad++; $display("FAIL b2b_miso1: got %h want c3", mb2[15:8]); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL b2b_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_continuous();
    logic [15:0] mb;
    int r0, u0;
    load(8'h96);
    r0 = rxv_cnt; u0 = und_cnt;
    frame(16, 16'hF00F, 1'b0, 3, 8'h3A, 20, mb);
    total++; if (rxv_cnt - r0 !== 2) begin bad++; $display("FAIL cont_rx_count: got %0d want 2", rxv_cnt - r0); end
    total++; if (rx_log[r0[5:0]] !== 8'hF0) begin bad++; $display("FAIL cont_rx0: got %h want f0", rx_log[r0[5:0]]); end
    total++; if (rx_log[(r0 + 1) % 64] !== 8'h0F) begin bad++; $display("FAIL cont_rx1: got %h want 0f", rx_log[(r0 + 1) % 64]); end
    total++; if (mb !== 16'h963A) begin bad++; $display("FAIL cont_miso: got %h want 963a", mb); end
    total++; if (und_cnt - u0 !== 0) begin bad++; $display("FAIL cont_underrun: got %0d want 0", und_cnt - u0); end
  endtask

  task automatic test_underrun();
    logic [15:0] mb;
    int r0, u0;
    load(8'h6B);
    r0 = rxv_cnt; u0 = und_cnt;
    frame(16, 16'h00FF, 1'b0, -1, 8'h00, 20, mb);
    total++; if (rxv_cnt - r0 !== 2) begin bad++; $display("FAIL und_rx_count: got %0d want 2", rxv_cnt - r0); end
    total++; if (rx_log[r0[5:0]] !== 8'h00) begin bad++; $display("FAIL und_rx0: got %h want 00", rx_log[r0[5:0]]); end
    total++; if (rx_log[(r0 + 1) % 64] !== 8'hFF) begin bad++; $display("FAIL und_rx1: got %h want ff", rx_log[(r0 + 1) % 64]); end
    total++; if (mb !== 16'h6B6B) begin bad++; $display("FAIL und_miso: got %h want 6b6b", mb); end
    total++; if (und_cnt - u0 !== 1) begin bad++; $display("FAIL und_pulses: got %0d want 1", und_cnt - u0); end
  endtask

  task automatic test_abort();
    logic [15:0] mb;
    int r0;
    r0 = rxv_cnt;
    frame(4, 16'hF000, 1'b1, -1, 8'h00, 20, mb);
    total++; if (rxv_cnt - r0 !== 0) begin bad++; $display("FAIL abort_rx_count: got %0d want 0", rxv_cnt - r0); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL abort_rx_hold: got %h want ff", rx_data); end
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL abort_miso: got %b want z(pulled 1)", MISO); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    load(8'hA7);
    r0 = rxv_cnt;
    frame(8, 16'h5A00, 1'b1, -1, 8'h00, 20, mb);
    total++; if (rxv_cnt - r0 !== 1) begin bad++; $display("FAIL abort_next_count: got %0d want 1", rxv_cnt - r0); end
    total++; if (rx_log[r0[5:0]] !== 8'h5A) begin bad++; $display("FAIL abort_next_rx: got %h want 5a", rx_log[r0[5:0]]); end
    total++; if (mb[15:8] !== 8'hA7) begin bad++; $display("FAIL abort_next_miso: got %h want a7", mb[15:8]); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] mb;
    int r0, u0;
    CS = 1'b0; SCLK = 1'b0; MOSI = 1'b1;
    cyc(HALF);
    for (int i = 0; i < 3; i++) begin
      SCLK = 1'b1; cyc(HALF);
      SCLK = 1'b0; cyc(HALF);
    end
    load(8'hE4);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL mid_tx_ready_before: got %b want 0", tx_ready); end
    rst = 1'b0;
    cyc(1);
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL mid_miso: got %b want z(pulled 1)", MISO); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_rx_data: got %h want 00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_rx_valid: got %b want 0", rx_valid); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_tx_ready: got %b want 1", tx_ready); end
    total++; if (tx_underrun !== 1'b0) begin bad++; $display("FAIL mid_underrun: got %b want 0", tx_underrun); end
    CS = 1'b1; MOSI = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(20);
    // tx_buf was cleared by reset: the next frame sends 0x00 as an underrun.
    r0 = rxv_cnt; u0 = und_cnt;
    frame(8, 16'hC600, 1'b0, -1, 8'h00, 20, mb);
    total++; if (mb[15:8] !== 8'h00) begin bad++; $display("FAIL mid_post_miso: got %h want 00", mb[15:8]); end
    total++; if (rx_log[r0[5:0]] !== 8'hC6) begin bad++; $display("FAIL mid_post_rx: got %h want c6", rx_log[r0[5:0]]); end
    total++; if (und_cnt - u0 !== 1) begin bad++; $display("FAIL mid_post_underrun: got %0d want 1", und_cnt - u0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_continuous();
    test_underrun();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
